// File: rtl/wb_port_sched.sv
// Register-file write-port scheduler: arbitrates in-order writeback against
// variable-latency load returns and tracks outstanding load destinations.
module wb_port_sched #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [1:0]  wb_sel,
    input  logic [4:0]  wb_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] imm,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic [1:0]  wsel,
    output logic [CW-1:0] pending_cnt,
    output logic        err_spurious
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_PC4  = 2'b10,
        SEL_IMM  = 2'b11
    } wsel_e;

    logic [4:0]       q [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] slot_valid;
    logic             hit_rs1, hit_rs2, hit_rd;
    logic             is_load, raw, waw, full, conflict;
    logic             accept, ret, enq;
    logic [4:0]       head;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        if (int'(p) == DEPTH - 1) return '0;
        return p + 1'b1;
    endfunction

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = ((i - int'(rd_ptr) + DEPTH) % DEPTH) < int'(count);
        end
    end

    // NOTE: every variable written here gets a default first, so no path infers a latch.
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && q[i] == rs1)   hit_rs1 = 1'b1;
            if (slot_valid[i] && q[i] == rs2)   hit_rs2 = 1'b1;
            if (slot_valid[i] && q[i] == wb_rd) hit_rd  = 1'b1;
        end
        hit_rs1 = hit_rs1 && (rs1 != 5'd0);
        hit_rs2 = hit_rs2 && (rs2 != 5'd0);
        hit_rd  = hit_rd  && (wb_rd != 5'd0);
    end

    assign is_load  = (wb_sel == SEL_LOAD);
    assign raw      = (rs1_used && hit_rs1) || (rs2_used && hit_rs2);
    assign waw      = !is_load && hit_rd;
    assign full     = (int'(count) == DEPTH) && !mem_rvalid;
    assign conflict = !is_load && mem_rvalid;
    assign stall    = wb_valid && (raw || waw || conflict || (is_load && full));
    assign accept   = wb_valid && !stall;
    assign ret      = mem_rvalid && (count != '0);
    assign enq      = accept && is_load;
    assign head     = q[rd_ptr];

    assign pending_cnt = count;

    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = wb_rd;
        rf_wdata = alu_result;
        wsel     = SEL_ALU;
        if (ret) begin
            rf_we    = (head != 5'd0);
            rf_rd    = head;
            rf_wdata = mem_rdata;
            wsel     = SEL_LOAD;
        end else if (accept && !is_load) begin
            rf_we = (wb_rd != 5'd0);
            wsel  = wb_sel;
            case (wb_sel)
                SEL_PC4: rf_wdata = pc_plus4;
                SEL_IMM: rf_wdata = imm;
                default: rf_wdata = alu_result;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (enq) wr_ptr <= bump(wr_ptr);
            if (ret) rd_ptr <= bump(rd_ptr);
            case ({enq, ret})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (mem_rvalid && count == '0) err_spurious <= 1'b1;
        end
    end

    // NOTE: queue storage is not reset; entries outside the live window are never observed.
    always_ff @(posedge clk) begin
        if (enq) q[wr_ptr] <= wb_rd;
    end

endmodule

// File: tb/tb_wb_port_sched.sv
// Self-checking bench for wb_port_sched: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_port_sched;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic [1:0]  wb_sel = '0;
    logic [4:0]  wb_rd = '0, rs1 = '0, rs2 = '0;
    logic        rs1_used = 1'b0, rs2_used = 1'b0;
    logic [31:0] alu_result = '0, pc_plus4 = '0, imm = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall, rf_we, err_spurious;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [1:0]  wsel;
    logic [CW-1:0] pending_cnt;

    wb_port_sched #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_rd(wb_rd),
        .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .alu_result(alu_result), .pc_plus4(pc_plus4), .imm(imm),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .wsel(wsel), .pending_cnt(pending_cnt), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int step_no = 0;
    bit running = 1'b0;

    int pq[$];
    bit m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (pq[i]) if (pq[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: pending loads as an ordered list of destinations.
    always @(negedge clk) begin
        bit e_ret, e_stall, e_acc, e_we, hazard, e_spur;
        logic [1:0]  e_wsel;
        logic [4:0]  e_rd;
        logic [31:0] e_wdata;
        if (running) begin
            if (rst) begin
                pq.delete();
                m_err = 1'b0;
            end
            e_ret  = mem_rvalid && pq.size() > 0;
            e_spur = mem_rvalid && pq.size() == 0;
            hazard = (rs1_used && m_hit(rs1)) || (rs2_used && m_hit(rs2))
                  || (wb_sel != 2'b01 && (m_hit(wb_rd) || mem_rvalid))
                  || (wb_sel == 2'b01 && pq.size() == DEPTH && !mem_rvalid);
            e_stall = wb_valid && hazard;
            e_acc   = wb_valid && !e_stall;
            e_we = 1'b0; e_wsel = 2'b00; e_rd = 5'd0; e_wdata = alu_result;
            if (e_ret) begin
                e_rd = 5'(pq[0]); e_we = (pq[0] != 0); e_wsel = 2'b01; e_wdata = mem_rdata;
            end else if (e_acc && wb_sel != 2'b01) begin
                e_rd = wb_rd; e_we = (wb_rd != 0); e_wsel = wb_sel;
                e_wdata = (wb_sel == 2'b10) ? pc_plus4 : (wb_sel == 2'b11) ? imm : alu_result;
            end
            check("stall", stall, e_stall);
            check("rf_we", rf_we, e_we);
            check("pending_cnt", pending_cnt, pq.size());
            check("err_spurious", err_spurious, m_err);
            if (!e_spur) check("wsel", wsel, e_wsel);
            if (e_ret || (e_acc && wb_sel != 2'b01)) check("rf_rd", rf_rd, e_rd);
            if (!e_spur && !(e_acc && wb_sel == 2'b01)) check("rf_wdata", rf_wdata, e_wdata);
            if (!rst) begin
                if (e_ret) void'(pq.pop_front());
                else if (mem_rvalid) m_err = 1'b1;
                if (e_acc && wb_sel == 2'b01) pq.push_back(int'(wb_rd));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
        step_no++;
        wb_valid = 0; wb_sel = 0; wb_rd = 0; rs1 = 0; rs2 = 0;
        rs1_used = 0; rs2_used = 0; pc_plus4 = 0; imm = 0;
        mem_rvalid = 0; mem_rdata = 0;
        alu_result = 32'hA110_0000 + 32'(step_no);
    endtask

    task automatic op(input logic [1:0] sel, input logic [4:0] rd);
        wb_valid = 1'b1; wb_sel = sel; wb_rd = rd;
    endtask

    task automatic ret(input logic [31:0] d);
        mem_rvalid = 1'b1; mem_rdata = d;
    endtask

    int exp_order[6] = '{12, 13, 14, 15, 16, 17};

    initial begin
        next();
        running = 1'b1;
        next();
        rst = 1'b0;
        #2;
        check("reset_pending", pending_cnt, 0);
        check("reset_stall", stall, 0);

        // ALU / PC+4 / immediate writeback
        next(); op(2'b00, 5'd3); alu_result = 32'h1234;
        #2; check("alu_we", rf_we, 1); check("alu_rd", rf_rd, 3);
        check("alu_data", rf_wdata, 32'h1234); check("alu_stall", stall, 0);
        next(); op(2'b00, 5'd0); alu_result = 32'h55;
        #2; check("alu_x0_we", rf_we, 0);
        next(); op(2'b10, 5'd1); pc_plus4 = 32'h200;
        next(); op(2'b11, 5'd2); imm = 32'hABCD_E000;
        #2; check("imm_data", rf_wdata, 32'hABCD_E000);

        // load then use
        next(); op(2'b01, 5'd7);
        #2; check("load_no_we", rf_we, 0);
        next(); op(2'b00, 5'd10); rs1 = 5'd7; rs1_used = 1'b1;
        #2; check("raw_stall", stall, 1); check("raw_pending", pending_cnt, 1);
        next(); op(2'b00, 5'd10); rs1 = 5'd7; rs1_used = 1'b1;
        next(); op(2'b00, 5'd10); rs1 = 5'd7; rs1_used = 1'b1; ret(32'hCAFE_F00D);
        #2; check("raw_nobypass", stall, 1); check("ret_rd", rf_rd, 7);
        check("ret_data", rf_wdata, 32'hCAFE_F00D); check("ret_wsel", wsel, 2'b01);
        next(); op(2'b00, 5'd10); rs1 = 5'd7; rs1_used = 1'b1;
        #2; check("raw_clear", stall, 0); check("use_rd", rf_rd, 10);

        // port conflict
        next(); op(2'b01, 5'd9);
        next(); op(2'b10, 5'd4); pc_plus4 = 32'h100; ret(32'h99);
        #2; check("conf_stall", stall, 1); check("conf_rd", rf_rd, 9);
        next(); op(2'b10, 5'd4); pc_plus4 = 32'h100;
        #2; check("conf_after_data", rf_wdata, 32'h100); check("conf_after_wsel", wsel, 2'b10);

        // queue full and pointer wrap
        for (int k = 0; k < 4; k++) begin
            next(); op(2'b01, 5'(11 + k));
        end
        next(); op(2'b01, 5'd15);
        #2; check("full_stall", stall, 1); check("full_cnt", pending_cnt, 4);
        next(); op(2'b01, 5'd15); ret(32'h1011);
        #2; check("full_ret_accept", stall, 0); check("full_ret_rd", rf_rd, 11);
        next();
        #2; check("full_cnt_kept", pending_cnt, 4);
        for (int k = 0; k < 6; k++) begin
            next();
            if (k < 2) op(2'b01, 5'(16 + k));
            ret(32'h2000 + 32'(k));
            #2; check("drain_rd", rf_rd, exp_order[k]); check("drain_we", rf_we, 1);
        end
        next();
        #2; check("drain_empty", pending_cnt, 0);

        // WAW
        next(); op(2'b01, 5'd8);
        next(); op(2'b11, 5'd8); imm = 32'h1234_5000;
        #2; check("waw_stall", stall, 1);
        next(); op(2'b11, 5'd8); imm = 32'h1234_5000; ret(32'h88);
        #2; check("waw_ret_stall", stall, 1); check("waw_ret_data", rf_wdata, 32'h88);
        next(); op(2'b11, 5'd8); imm = 32'h1234_5000;
        #2; check("waw_final_stall", stall, 0); check("waw_final_data", rf_wdata, 32'h1234_5000);
        check("waw_final_rd", rf_rd, 8);

        // load to x0, and x0 sources never hazard
        next(); op(2'b01, 5'd0);
        next(); op(2'b00, 5'd1); rs1_used = 1'b1; rs2_used = 1'b1;
        #2; check("x0_no_raw", stall, 0);
        next(); ret(32'h5);
        #2; check("x0_ret_we", rf_we, 0); check("x0_ret_wsel", wsel, 2'b01);

        // rs2 hazard gated by rs2_used
        next(); op(2'b01, 5'd20);
        next(); op(2'b00, 5'd2); rs2 = 5'd20;
        #2; check("rs2_unused", stall, 0);
        next(); op(2'b00, 5'd2); rs2 = 5'd20; rs2_used = 1'b1;
        #2; check("rs2_stall", stall, 1);
        next(); op(2'b00, 5'd2); rs2 = 5'd20; rs2_used = 1'b1; ret(32'h20);
        next(); op(2'b00, 5'd2); rs2 = 5'd20; rs2_used = 1'b1;
        #2; check("rs2_clear", stall, 0);

        // reset mid-flight, then a spurious return
        next(); op(2'b01, 5'd5);
        next(); op(2'b01, 5'd6);
        next(); rst = 1'b1;
        #2; check("rst_async_cnt", pending_cnt, 0);
        next(); rst = 1'b0;
        next(); ret(32'hDEAD);
        #2; check("spur_we", rf_we, 0); check("spur_stall", stall, 0);
        next();
        #2; check("spur_err", err_spurious, 1);
        next();
        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
